debug_pattern_generator_3: RTL and testbench
============================================

Name: debug_pattern_generator_3

Overview:
Parametrised successor to the color-bar debug source. It generates synthetic RGB565 frames for the framebuffer path in four runtime-selectable modes: color bars, gray gradient, checkerboard and solid color. Scrolling moves the pattern per frame. Frame, row and end commands go out over the command valid/ready handshake, and the memory writer reads pixels by word address. It runs on one clock and replaces the camera source during bring-up.

Parameters:
FRAME_WIDTH, 640, pixels per row; must be a multiple of PIXELS_PER_WORD.
FRAME_HEIGHT, 480, rows per frame.
PIXELS_PER_WORD, 2, pixels packed per pixel_data word (1, 2 or 4).
NUM_COLOR_BARS, 10, bar count in mode 0 (1..10).
GRAD_SHIFT, 4, gradient level is (x >> GRAD_SHIFT) & 31.
CHECK_SHIFT, 3, checker cell size is 2^CHECK_SHIFT pixels.
SCROLL_STEP, 64, horizontal pixel offset added per frame when scrolling.
FRAME_GAP, 16, idle cycles after FRAME_END before the next FRAME_START.
ADDR_WIDTH, $clog2(FRAME_WIDTH/PIXELS_PER_WORD), word address width.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
init  in  1  downstream ready (PLL lock); no frame starts while low
enable  in  1  continuous frame generation request
mode  in  2  0 bars, 1 gradient, 2 checker, 3 solid
scroll_en  in  1  apply per-frame horizontal offset
solid_color  in  16  RGB565 value for mode 3
mem_controller_rdy  in  1  consumer accepts the current command
command_data_valid  out  1  command presented
command_data  out  2  1 FRAME_START, 2 ROW_START, 3 FRAME_END
mem_addr  in  ADDR_WIDTH  word index within the current row
pixel_data  out  16*PIXELS_PER_WORD  pixels; the lowest x is in the lowest 16 bits
frame_count  out  16  completed frames, wraps at 65535
busy  out  1  high from FRAME_START presented until FRAME_END accepted

Behaviour:
- Clocking and reset: one clock domain. Reset is synchronous, active-high. While reset is high, all outputs are 0, state is IDLE, frame_count is 0, and active_row and the latched config are 0.
- Handshake: a command transfers on any cycle with command_data_valid && mem_controller_rdy.
  - Once asserted, valid and data hold stable until that transfer.
  - After a transfer, the next command may appear on the following cycle. Valid may stay high back-to-back.
- States: IDLE, CMD_FRAME_START, CMD_ROW_START, CMD_FRAME_END, GAP.
- IDLE: moves to CMD_FRAME_START when init && enable.
- FRAME_START accepted:
  - latch mode, scroll_en and solid_color; later input changes have no effect until the next frame;
  - row_idx = 0; move to CMD_ROW_START.
- ROW_START accepted:
  - active_row = row_idx, which selects the row used for pixel lookup;
  - if row_idx == FRAME_HEIGHT-1, move to CMD_FRAME_END; otherwise row_idx++ and stay in CMD_ROW_START.
- FRAME_END accepted: frame_count++ and move to GAP.
- GAP: counts FRAME_GAP cycles, then goes to CMD_FRAME_START if init && enable, else IDLE.
- enable deasserted mid-frame: the current frame completes. init low mid-frame has no effect.
- Pixel path: pixel_data is registered, with latency 1 cycle from mem_addr. The output is valid in any state and uses active_row.
  - Pixel x = mem_addr*PIXELS_PER_WORD + k.
  - With scroll, xs = (x + frame_count*SCROLL_STEP) mod FRAME_WIDTH. Implement this with a running offset register updated at FRAME_END: subtract-on-overflow, no divider.
- Mode 0 (bars): bar width BW = FRAME_WIDTH/NUM_COLOR_BARS, rounded down. The color is BAR_COLORS[i] for the first i with xs < (i+1)*BW. Pixels beyond NUM_COLOR_BARS*BW are 0x0000.
- Mode 1 (gradient): L = (xs>>GRAD_SHIFT) & 31; pixel = {L, L<<1 (6 bits), L}.
- Mode 2 (checker): pixel = ((xs>>CHECK_SHIFT) ^ (active_row>>CHECK_SHIFT)) & 1 ? 0xFFFF : 0x0000.
- Mode 3 (solid): pixel = latched solid_color.
- mem_addr beyond the row: any out-of-range address returns 0.
- Reset mid-frame: abort immediately to IDLE. No FRAME_END is issued.

Decomposition:
- Package debug_pattern_pkg:
  - pattern_mode_t enum;
  - command codes CMD_FRAME_START, CMD_ROW_START, CMD_FRAME_END;
  - BAR_COLORS table: FFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000, 8410, FD20;
  - rgb565 pack function.
- Sub-module pattern_pixel_lut: purely combinational, one instance per pixel lane. It maps (xs, active_row, latched mode, solid_color) to 16 bits. The top level registers the lane outputs.

Test Plan:
- 640x20, 2 pixels per word, mode 0, rdy toggled after each valid: sequence 1, then twenty 2s, then 3; frame_count=1; busy falls on the FRAME_END transfer.
- Mode 0, after the row-0 ROW_START, sweep mem_addr: addr 0 -> 0xFFFFFFFF, addr 32 -> 0xFFE0FFE0, addr 319 -> 0xFD20FD20, each one cycle after the address.
- Mode 1, GRAD_SHIFT=4: pixel x=160 (addr 80, low lane) -> 0x528A. Mode 2, CHECK_SHIFT=3: row 0 addr 0 -> 0x00000000, addr 4 -> 0xFFFFFFFF; row 8 addr 0 -> 0xFFFFFFFF.
- scroll_en=1, SCROLL_STEP=64, mode 0, second frame: addr 0 -> 0xFFE0FFE0. Mode changed mid-frame to 3: the current frame stays bars, and the next frame is solid_color.
- Backpressure: hold rdy low for 50 cycles while CMD_ROW_START is pending -> valid stays 1 and command_data stays 2, stable, with no row skipped. enable dropped mid-frame -> the frame completes, then IDLE with valid 0.
- Reset pulsed at row 7 -> the next cycle has all outputs 0 and frame_count 0. After release with init && enable, the next command is FRAME_START (1).

Source files
------------

// File: rtl/debug_pattern_pkg.sv
// Shared types, command codes and color helpers for the debug pattern generator.
package debug_pattern_pkg;

  typedef enum logic [1:0] {
    MODE_BARS  = 2'd0,
    MODE_GRAD  = 2'd1,
    MODE_CHECK = 2'd2,
    MODE_SOLID = 2'd3
  } pattern_mode_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FRAME_START,
    ST_ROW_START,
    ST_FRAME_END,
    ST_GAP
  } gen_state_t;

  localparam logic [1:0] CMD_FRAME_START = 2'd1;
  localparam logic [1:0] CMD_ROW_START   = 2'd2;
  localparam logic [1:0] CMD_FRAME_END   = 2'd3;

  localparam int unsigned NUM_BAR_COLORS = 10;

  localparam logic [15:0] BAR_COLORS [NUM_BAR_COLORS] = '{
    16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0, 16'hF81F,
    16'hF800, 16'h001F, 16'h0000, 16'h8410, 16'hFD20
  };

  function automatic logic [15:0] bar_color(input logic [3:0] idx);
    logic [15:0] color;
    color = 16'h0000;
    if (32'(idx) < NUM_BAR_COLORS) color = BAR_COLORS[idx];
    return color;
  endfunction

  function automatic logic [15:0] rgb565(input logic [4:0] r, input logic [5:0] g,
                                         input logic [4:0] b);
    return {r, g, b};
  endfunction

endpackage

// File: rtl/pattern_pixel_lut.sv
// One pixel lane: maps a scrolled x, the active row and the latched frame config to RGB565.
module pattern_pixel_lut
  import debug_pattern_pkg::*;
#(
  parameter int unsigned FRAME_WIDTH    = 640,
  parameter int unsigned NUM_COLOR_BARS = 10,
  parameter int unsigned GRAD_SHIFT     = 4,
  parameter int unsigned CHECK_SHIFT    = 3,
  parameter int unsigned XS_WIDTH       = 11,
  parameter int unsigned ROW_WIDTH      = 9
) (
  input  logic [XS_WIDTH-1:0]  i_xs,
  input  logic [ROW_WIDTH-1:0] i_row,
  input  pattern_mode_t        i_mode,
  input  logic [15:0]          i_solid_color,
  output logic [15:0]          o_pixel_c
);

  localparam int unsigned BAR_WIDTH = FRAME_WIDTH / NUM_COLOR_BARS;

  logic [4:0] w_level;
  logic       w_cell;
  logic       w_bar_hit;

  assign w_level = 5'(i_xs >> GRAD_SHIFT);
  assign w_cell  = 1'(i_xs >> CHECK_SHIFT) ^ 1'(i_row >> CHECK_SHIFT);

  always_comb begin
    o_pixel_c = 16'h0000;
    w_bar_hit = 1'b0;
    case (i_mode)
      MODE_BARS: begin
        // First bar whose right edge lies beyond xs wins; the ragged tail stays black.
        for (int unsigned i = 0; i < NUM_COLOR_BARS; i++) begin
          if (!w_bar_hit && (32'(i_xs) < (i + 1) * BAR_WIDTH)) begin
            o_pixel_c = bar_color(4'(i));
            w_bar_hit = 1'b1;
          end
        end
      end
      MODE_GRAD:  o_pixel_c = rgb565(w_level, {w_level, 1'b0}, w_level);
      MODE_CHECK: o_pixel_c = w_cell ? 16'hFFFF : 16'h0000;
      MODE_SOLID: o_pixel_c = i_solid_color;
      default:    o_pixel_c = 16'h0000;
    endcase
  end

endmodule

// File: rtl/debug_pattern_generator_3.sv
// Synthetic RGB565 frame source: command sequencer plus a registered, word-addressed pixel path.
module debug_pattern_generator_3
  import debug_pattern_pkg::*;
#(
  parameter int unsigned FRAME_WIDTH     = 640,
  parameter int unsigned FRAME_HEIGHT    = 480,
  parameter int unsigned PIXELS_PER_WORD = 2,
  parameter int unsigned NUM_COLOR_BARS  = 10,
  parameter int unsigned GRAD_SHIFT      = 4,
  parameter int unsigned CHECK_SHIFT     = 3,
  parameter int unsigned SCROLL_STEP     = 64,
  parameter int unsigned FRAME_GAP       = 16,
  parameter int unsigned ADDR_WIDTH      = $clog2(FRAME_WIDTH / PIXELS_PER_WORD)
) (
  input  logic                           i_clk,
  input  logic                           i_reset,
  input  logic                           i_init,
  input  logic                           i_enable,
  input  logic [1:0]                     i_mode,
  input  logic                           i_scroll_en,
  input  logic [15:0]                    i_solid_color,
  input  logic                           i_mem_controller_rdy,
  output logic                           o_command_data_valid,
  output logic [1:0]                     o_command_data,
  input  logic [ADDR_WIDTH-1:0]          i_mem_addr,
  output logic [16*PIXELS_PER_WORD-1:0]  o_pixel_data,
  output logic [15:0]                    o_frame_count,
  output logic                           o_busy
);

  // x spans the whole address range; one extra bit holds x + offset before the wrap.
  localparam int unsigned X_WIDTH   = ADDR_WIDTH + $clog2(PIXELS_PER_WORD) + 1;
  localparam int unsigned ROW_WIDTH = (FRAME_HEIGHT > 1) ? $clog2(FRAME_HEIGHT) : 1;
  localparam int unsigned GAP_WIDTH = (FRAME_GAP > 0) ? $clog2(FRAME_GAP + 1) : 1;
  localparam int unsigned GAP_LAST  = (FRAME_GAP > 0) ? FRAME_GAP - 1 : 0;
  localparam int unsigned STEP_MOD  = SCROLL_STEP % FRAME_WIDTH;

  gen_state_t             r_state;
  logic                   r_cmd_valid;
  logic [1:0]             r_cmd_data;
  logic                   r_busy;
  logic [15:0]            r_frame_count;
  logic [ROW_WIDTH-1:0]   r_row_idx;
  logic [ROW_WIDTH-1:0]   r_active_row;
  logic [GAP_WIDTH-1:0]   r_gap_cnt;
  pattern_mode_t          r_mode;
  logic                   r_scroll_en;
  logic [15:0]            r_solid_color;
  logic [X_WIDTH-1:0]     r_scroll_off;
  logic [16*PIXELS_PER_WORD-1:0] r_pixel_data;

  logic                   w_fire;
  logic                   w_start_ok;
  logic [X_WIDTH-1:0]     w_off_sum;
  logic [X_WIDTH-1:0]     w_off_next;
  logic [16*PIXELS_PER_WORD-1:0] w_pixel_word;

  assign w_fire     = r_cmd_valid && i_mem_controller_rdy;
  assign w_start_ok = i_init && i_enable;
  assign w_off_sum  = r_scroll_off + X_WIDTH'(STEP_MOD);
  assign w_off_next = (w_off_sum >= X_WIDTH'(FRAME_WIDTH)) ?
                      w_off_sum - X_WIDTH'(FRAME_WIDTH) : w_off_sum;

  // Command sequencer: valid/data change only on a transfer or when leaving IDLE/GAP.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state       <= ST_IDLE;
      r_cmd_valid   <= 1'b0;
      r_cmd_data    <= 2'd0;
      r_busy        <= 1'b0;
      r_frame_count <= 16'd0;
      r_row_idx     <= '0;
      r_active_row  <= '0;
      r_gap_cnt     <= '0;
      r_mode        <= MODE_BARS;
      r_scroll_en   <= 1'b0;
      r_solid_color <= 16'h0000;
      r_scroll_off  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_start_ok) begin
            r_state     <= ST_FRAME_START;
            r_cmd_valid <= 1'b1;
            r_cmd_data  <= CMD_FRAME_START;
            r_busy      <= 1'b1;
          end
        end
        ST_FRAME_START: begin
          if (w_fire) begin
            r_mode        <= pattern_mode_t'(i_mode);
            r_scroll_en   <= i_scroll_en;
            r_solid_color <= i_solid_color;
            r_row_idx     <= '0;
            r_state       <= ST_ROW_START;
            r_cmd_data    <= CMD_ROW_START;
          end
        end
        ST_ROW_START: begin
          if (w_fire) begin
            r_active_row <= r_row_idx;
            if (r_row_idx == ROW_WIDTH'(FRAME_HEIGHT - 1)) begin
              r_state    <= ST_FRAME_END;
              r_cmd_data <= CMD_FRAME_END;
            end else begin
              r_row_idx <= r_row_idx + ROW_WIDTH'(1);
            end
          end
        end
        ST_FRAME_END: begin
          if (w_fire) begin
            r_cmd_valid   <= 1'b0;
            r_cmd_data    <= 2'd0;
            r_busy        <= 1'b0;
            r_frame_count <= r_frame_count + 16'd1;
            r_scroll_off  <= w_off_next;
            r_gap_cnt     <= '0;
            r_state       <= ST_GAP;
          end
        end
        ST_GAP: begin
          if (r_gap_cnt == GAP_WIDTH'(GAP_LAST)) begin
            if (w_start_ok) begin
              r_state     <= ST_FRAME_START;
              r_cmd_valid <= 1'b1;
              r_cmd_data  <= CMD_FRAME_START;
              r_busy      <= 1'b1;
            end else begin
              r_state <= ST_IDLE;
            end
          end else begin
            r_gap_cnt <= r_gap_cnt + GAP_WIDTH'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  for (genvar k = 0; k < PIXELS_PER_WORD; k++) begin : g_lane
    logic [X_WIDTH-1:0] w_x;
    logic [X_WIDTH-1:0] w_xs_raw;
    logic [X_WIDTH-1:0] w_xs;
    logic [15:0]        w_lane_px;

    assign w_x      = X_WIDTH'(i_mem_addr) * X_WIDTH'(PIXELS_PER_WORD) + X_WIDTH'(k);
    assign w_xs_raw = w_x + (r_scroll_en ? r_scroll_off : '0);
    assign w_xs     = (w_xs_raw >= X_WIDTH'(FRAME_WIDTH)) ?
                      w_xs_raw - X_WIDTH'(FRAME_WIDTH) : w_xs_raw;

    pattern_pixel_lut #(
      .FRAME_WIDTH    (FRAME_WIDTH),
      .NUM_COLOR_BARS (NUM_COLOR_BARS),
      .GRAD_SHIFT     (GRAD_SHIFT),
      .CHECK_SHIFT    (CHECK_SHIFT),
      .XS_WIDTH       (X_WIDTH),
      .ROW_WIDTH      (ROW_WIDTH)
    ) u_lut (
      .i_xs          (w_xs),
      .i_row         (r_active_row),
      .i_mode        (r_mode),
      .i_solid_color (r_solid_color),
      .o_pixel_c     (w_lane_px)
    );

    // Addresses past the end of the row read as black.
    assign w_pixel_word[16*k +: 16] = (w_x < X_WIDTH'(FRAME_WIDTH)) ? w_lane_px : 16'h0000;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) r_pixel_data <= '0;
    else         r_pixel_data <= w_pixel_word;
  end

  assign o_command_data_valid = r_cmd_valid;
  assign o_command_data       = r_cmd_data;
  assign o_pixel_data         = r_pixel_data;
  assign o_frame_count        = r_frame_count;
  assign o_busy               = r_busy;

endmodule

// File: tb/tb_debug_pattern_generator_3.sv
// Scoreboard bench: expected commands/pixels are queued at stimulus time and popped by a monitor.
module tb_debug_pattern_generator_3;

  localparam int W    = 640;
  localparam int H    = 20;
  localparam int PPW  = 2;
  localparam int NB   = 10;
  localparam int GS   = 4;
  localparam int CS   = 3;
  localparam int STEP = 64;
  localparam int GAP  = 16;
  localparam int AW   = 9;

  localparam logic [15:0] BAR_TAB [10] = '{
    16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0, 16'hF81F,
    16'hF800, 16'h001F, 16'h0000, 16'h8410, 16'hFD20
  };

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          init = 1'b0;
  logic          enable = 1'b0;
  logic [1:0]    mode = 2'd0;
  logic          scroll_en = 1'b0;
  logic [15:0]   solid = 16'h0000;
  logic          rdy = 1'b0;
  logic          valid;
  logic [1:0]    cdata;
  logic [AW-1:0] mem_addr = '0;
  logic [31:0]   pix;
  logic [15:0]   fc;
  logic          busy;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state, advanced by the monitor from the expected command stream.
  int          m_mode = 0;
  bit          m_scroll = 1'b0;
  logic [15:0] m_solid = 16'h0;
  int          m_fc = 0;
  int          m_row = 0;
  int          m_row_idx = 0;

  logic [1:0]  cmd_q [$];
  logic [31:0] pix_q [$];
  logic        px_req = 1'b0;
  logic        px_pend = 1'b0;
  logic        hold_prev = 1'b0;
  logic [1:0]  hold_data = 2'd0;
  logic        fe_prev = 1'b0;

  debug_pattern_generator_3 #(
    .FRAME_WIDTH(W), .FRAME_HEIGHT(H), .PIXELS_PER_WORD(PPW), .NUM_COLOR_BARS(NB),
    .GRAD_SHIFT(GS), .CHECK_SHIFT(CS), .SCROLL_STEP(STEP), .FRAME_GAP(GAP), .ADDR_WIDTH(AW)
  ) dut (
    .i_clk(clk), .i_reset(reset), .i_init(init), .i_enable(enable), .i_mode(mode),
    .i_scroll_en(scroll_en), .i_solid_color(solid), .i_mem_controller_rdy(rdy),
    .o_command_data_valid(valid), .o_command_data(cdata), .i_mem_addr(mem_addr),
    .o_pixel_data(pix), .o_frame_count(fc), .o_busy(busy)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] ref_px(input int x);
    int xs;
    int bw;
    logic [4:0] lv;
    bw = W / NB;
    if (x >= W) return 16'h0000;
    xs = m_scroll ? (x + m_fc * STEP) % W : x;
    case (m_mode)
      0: return (xs / bw < NB) ? BAR_TAB[xs / bw] : 16'h0000;
      1: begin
        lv = 5'((xs >> GS) & 31);
        return {lv, lv, 1'b0, lv};
      end
      2: return ((((xs >> CS) ^ (m_row >> CS)) & 1) != 0) ? 16'hFFFF : 16'h0000;
      default: return m_solid;
    endcase
  endfunction

  always @(posedge clk) px_pend <= px_req;

  // Monitor: handshake stability, command scoreboard and pixel scoreboard.
  always @(negedge clk) begin
    logic [1:0] exp_c;
    if (hold_prev && !reset) begin
      check("hold_valid", 32'(valid), 32'(1));
      check("hold_data", 32'(cdata), 32'(hold_data));
    end
    if (fe_prev && !reset) check("busy_after_end", 32'(busy), 32'(0));
    fe_prev = 1'b0;
    if (px_pend) begin
      if (pix_q.size() == 0) check("pixel_queue", 32'(1), 32'(0));
      else check("pixel", pix, pix_q.pop_front());
    end
    if (valid && rdy && !reset) begin
      check("busy_on_xfer", 32'(busy), 32'(1));
      if (cmd_q.size() == 0) begin
        check("unexpected_cmd", 32'(cdata), 32'(0));
      end else begin
        exp_c = cmd_q.pop_front();
        check("command", 32'(cdata), 32'(exp_c));
        case (exp_c)
          2'd1: begin
            m_mode = int'(mode); m_scroll = scroll_en; m_solid = solid; m_row_idx = 0;
          end
          2'd2: begin
            m_row = m_row_idx; m_row_idx++;
          end
          default: begin
            m_fc = (m_fc + 1) % 65536; fe_prev = 1'b1;
          end
        endcase
      end
    end
    hold_prev = valid && !rdy && !reset;
    hold_data = cdata;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept n commands; style 0 = rdy high, 1 = toggling, 2 = random.
  task automatic run_cmds(input int n, input int style);
    int got = 0;
    int guard = 0;
    while (got < n && guard < 5000) begin
      case (style)
        0:       rdy = 1'b1;
        1:       rdy = ~rdy;
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      @(negedge clk);
      if (valid && rdy) got++;
      tick();
      guard++;
    end
    rdy = 1'b0;
    if (got < n) check("run_cmds_timeout", 32'(got), 32'(n));
  endtask

  task automatic start_frame(input int md, input bit sc, input logic [15:0] sol, input int style);
    mode = 2'(md); scroll_en = sc; solid = sol; init = 1'b1; enable = 1'b1;
    cmd_q.push_back(2'd1);
    for (int r = 0; r < H; r++) cmd_q.push_back(2'd2);
    cmd_q.push_back(2'd3);
    run_cmds(1, style);
    enable = 1'b0;
  endtask

  task automatic check_pix(input int addr);
    logic [31:0] e;
    e = {ref_px(addr * PPW + 1), ref_px(addr * PPW)};
    mem_addr = AW'(addr);
    pix_q.push_back(e);
    px_req = 1'b1;
    tick();
    px_req = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_valid"}, 32'(valid), 32'(0));
    check({tag, "_busy"}, 32'(busy), 32'(0));
    check({tag, "_frame_count"}, 32'(fc), 32'(m_fc));
  endtask

  initial begin
    int rows;
    repeat (3) tick();
    @(negedge clk);
    check("rst_valid", 32'(valid), 32'(0));
    check("rst_data", 32'(cdata), 32'(0));
    check("rst_pixel", pix, 32'(0));
    check("rst_frame_count", 32'(fc), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    tick();
    reset = 1'b0;

    // No frame may start while init is low.
    init = 1'b0; enable = 1'b1;
    repeat (30) tick();
    check("init_low_valid", 32'(valid), 32'(0));

    // Frame A: bars, toggling rdy, enable dropped right after FRAME_START.
    start_frame(0, 1'b0, 16'h0, 1);
    run_cmds(H + 1, 1);
    check("frameA_fc", 32'(fc), 32'(1));
    repeat (GAP + 4) tick();
    check_idle_outputs("frameA_idle");

    // Frame B: backpressure on ROW_START, then bar sweep on row 0.
    start_frame(0, 1'b0, 16'h0, 0);
    run_cmds(1, 0);
    repeat (50) tick();
    check("bp_valid", 32'(valid), 32'(1));
    check("bp_data", 32'(cdata), 32'(2));
    check_pix(0); check_pix(32); check_pix(319); check_pix(320); check_pix(511);
    repeat (6) check_pix($urandom_range(0, 319));
    run_cmds(H, 2);
    check("frameB_fc", 32'(fc), 32'(m_fc));

    // Frame C: gradient; mode input switched to solid mid-frame must not apply yet.
    start_frame(1, 1'b0, 16'h0, 0);
    run_cmds(1, 0);
    mode = 2'd3; solid = 16'($urandom);
    check_pix(80);
    repeat (6) check_pix($urandom_range(0, 319));
    run_cmds(H, 2);

    // Frame D: the solid color takes effect from the next frame.
    start_frame(3, 1'b0, solid, 0);
    run_cmds(3, 2);
    check_pix(5); check_pix(400);
    repeat (4) check_pix($urandom_range(0, 319));
    run_cmds(H - 2, 2);

    // Frame E: checkerboard on rows 0 and 8.
    start_frame(2, 1'b0, 16'h0, 0);
    run_cmds(1, 0);
    check_pix(0); check_pix(4);
    repeat (4) check_pix($urandom_range(0, 319));
    run_cmds(8, 2);
    check_pix(0); check_pix(4);
    repeat (4) check_pix($urandom_range(0, 319));
    run_cmds(H - 8, 2);
    check("frameE_fc", 32'(fc), 32'(m_fc));

    // Reset while row 7 is the active row.
    start_frame(0, 1'b0, 16'h0, 0);
    run_cmds(8, 0);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midrst_valid", 32'(valid), 32'(0));
    check("midrst_data", 32'(cdata), 32'(0));
    check("midrst_pixel", pix, 32'(0));
    check("midrst_frame_count", 32'(fc), 32'(0));
    check("midrst_busy", 32'(busy), 32'(0));
    cmd_q.delete();
    m_fc = 0; m_mode = 0; m_scroll = 1'b0; m_solid = 16'h0; m_row = 0; m_row_idx = 0;
    tick();
    reset = 1'b0;
    start_frame(0, 1'b0, 16'h0, 0);
    run_cmds(H + 1, 2);

    // Scrolling bars on the second frame after reset.
    start_frame(0, 1'b1, 16'h0, 0);
    run_cmds(1, 0);
    check_pix(0); check_pix(319);
    repeat (4) check_pix($urandom_range(0, 319));
    run_cmds(H, 2);

    // Randomized frames: config, rdy pattern, probed row, init and mode wiggles mid-frame.
    for (int f = 0; f < 10; f++) begin
      rows = $urandom_range(1, H);
      start_frame($urandom_range(0, 3), 1'($urandom_range(0, 1)), 16'($urandom), 2);
      init = 1'($urandom_range(0, 1));
      mode = 2'($urandom_range(0, 3));
      run_cmds(rows, 2);
      repeat (6) check_pix($urandom_range(0, 511));
      run_cmds(H + 1 - rows, 2);
      check("rand_fc", 32'(fc), 32'(m_fc));
    end

    repeat (GAP + 4) tick();
    check_idle_outputs("final_idle");
    check("cmd_queue_empty", 32'(cmd_q.size()), 32'(0));
    check("pix_queue_empty", 32'(pix_q.size()), 32'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
